// File: rtl/dht11_responder.sv
// dht11_responder
// Slave-side model of the DHT11 single-wire protocol. Waits for a host start
// pulse on dhtio, then answers with the sensor response and a 40-bit frame
// {humidity, temperature, checksum}, sent MSB first. The bus is open-drain:
// the block only pulls it low or releases it, and relies on a pull-up for
// every high level.
//
// Build option: define DHT11_RESP_CHKSUM_ERR_EN to add the inject_err input,
// which corrupts the checksum (XOR 8'h01) of the frame latched while it is high.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active high
//   enable       respond to start requests (looked at in IDLE only)
//   humidity     {integer, decimal} humidity bytes to report
//   temperature  {integer, decimal} temperature bytes to report
//   inject_err   (optional) send a bad checksum in the next latched frame
//   busy         high from start-request accept until back in IDLE
//   frame_done   one-cycle pulse after the trailing low completes
//   debug        current state encoding
//   dhtio        single-wire bus, driven 0 or released to Z
//
// State    | code | meaning
// IDLE     | 0    | bus released, waiting for a host falling edge
// HOST_LOW | 1    | timing the host start pulse
// WAIT_REL | 2    | released, delay before answering
// RESP_L   | 3    | response low
// RESP_H   | 4    | response released
// BIT_L    | 5    | low period opening a data bit
// BIT_H    | 6    | released period, length encodes the bit value
// END_L    | 7    | trailing low after the last bit

module dht11_responder #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int MIN_START_US  = 18000,
    parameter int RESP_DELAY_US = 30,
    parameter int RESP_LOW_US   = 80,
    parameter int RESP_HIGH_US  = 80,
    parameter int BIT_LOW_US    = 50,
    parameter int BIT0_HIGH_US  = 26,
    parameter int BIT1_HIGH_US  = 70,
    parameter int END_LOW_US    = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
`ifdef DHT11_RESP_CHKSUM_ERR_EN
    input  logic        inject_err,
`endif
    output logic        busy,
    output logic        frame_done,
    output logic [3:0]  debug,
    inout  wire         dhtio
);

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CYC_US      = CLK_FREQ / 1_000_000;
    localparam int START_CYC   = MIN_START_US  * CYC_US;
    localparam int DELAY_CYC   = RESP_DELAY_US * CYC_US;
    localparam int RESP_L_CYC  = RESP_LOW_US   * CYC_US;
    localparam int RESP_H_CYC  = RESP_HIGH_US  * CYC_US;
    localparam int BIT_L_CYC   = BIT_LOW_US    * CYC_US;
    localparam int BIT0_H_CYC  = BIT0_HIGH_US  * CYC_US;
    localparam int BIT1_H_CYC  = BIT1_HIGH_US  * CYC_US;
    localparam int END_L_CYC   = END_LOW_US    * CYC_US;

    localparam int MAX_CYC = max_i(max_i(max_i(START_CYC, DELAY_CYC),
                                         max_i(RESP_L_CYC, RESP_H_CYC)),
                                   max_i(max_i(BIT_L_CYC, BIT0_H_CYC),
                                         max_i(BIT1_H_CYC, END_L_CYC)));
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] HOST_LOW = 4'd1;
    localparam logic [3:0] WAIT_REL = 4'd2;
    localparam logic [3:0] RESP_L   = 4'd3;
    localparam logic [3:0] RESP_H   = 4'd4;
    localparam logic [3:0] BIT_L    = 4'd5;
    localparam logic [3:0] BIT_H    = 4'd6;
    localparam logic [3:0] END_L    = 4'd7;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [39:0]      shift_q, shift_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic [1:0]       sync_q;
    logic             prev_q;

    logic             bus_fall, bus_rise;
    logic             drive_low;
    logic [7:0]       chk_sum;
    logic [7:0]       chk_tx;
    logic [CNT_W-1:0] bit_h_last;

    // 2-FF synchronizer plus one history bit for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], dhtio};
            prev_q <= sync_q[1];
        end
    end

    assign bus_fall = prev_q & ~sync_q[1];
    assign bus_rise = ~prev_q & sync_q[1];

    assign chk_sum = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
`ifdef DHT11_RESP_CHKSUM_ERR_EN
    assign chk_tx = inject_err ? (chk_sum ^ 8'h01) : chk_sum;
`else
    assign chk_tx = chk_sum;
`endif

    assign bit_h_last = shift_q[39] ? CNT_W'(BIT1_H_CYC - 1) : CNT_W'(BIT0_H_CYC - 1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus_fall && enable) state_d = HOST_LOW;
            end
            HOST_LOW: begin
                // Saturate so an arbitrarily long host low cannot wrap.
                if (cnt_q >= CNT_W'(START_CYC)) cnt_d = cnt_q;
                if (bus_rise) begin
                    if (cnt_q >= CNT_W'(START_CYC)) begin
                        shift_d   = {humidity, temperature, chk_tx};
                        bit_cnt_d = '0;
                        busy_d    = 1'b1;
                        state_d   = WAIT_REL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            WAIT_REL: if (cnt_q == CNT_W'(DELAY_CYC - 1))  state_d = RESP_L;
            RESP_L:   if (cnt_q == CNT_W'(RESP_L_CYC - 1)) state_d = RESP_H;
            RESP_H:   if (cnt_q == CNT_W'(RESP_H_CYC - 1)) state_d = BIT_L;
            BIT_L:    if (cnt_q == CNT_W'(BIT_L_CYC - 1))  state_d = BIT_H;
            BIT_H: begin
                if (cnt_q == bit_h_last) begin
                    shift_d   = {shift_q[38:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 6'd39) ? END_L : BIT_L;
                end
            end
            END_L: begin
                if (cnt_q == CNT_W'(END_L_CYC - 1)) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every state entry starts its timer from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Decoded straight from the state register so an async reset releases
    // the bus without waiting for a clock edge.
    assign drive_low = (state_q == RESP_L) || (state_q == BIT_L) || (state_q == END_L);
    assign dhtio     = drive_low ? 1'b0 : 1'bz;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign debug      = state_q;

endmodule

// File: doc/dht11_responder.md
Name: dht11_responder

Overview:
- Slave-side model of the DHT11 single-wire protocol: detects the host start pulse on `dhtio`, then answers with the sensor response and a 40-bit frame (humidity, temperature, checksum).
- Used as the on-chip and simulation counterpart of the DHT11 host controller, for loopback bring-up without a physical sensor.
- Open-drain: the block only ever drives 0 or releases to Z; the bus relies on an external or bench pull-up for every high level.

Parameters:
- CLK_FREQ, 100_000_000: clock frequency in Hz. CYC_US = CLK_FREQ/1_000_000 cycles per µs.
- MIN_START_US, 18000: minimum host low time accepted as a start request.
- RESP_DELAY_US, 30: released time after the host's rising edge before the block answers.
- RESP_LOW_US, 80: response low period.
- RESP_HIGH_US, 80: response released (high) period.
- BIT_LOW_US, 50: low period that opens each bit.
- BIT0_HIGH_US, 26: released period for a '0' bit.
- BIT1_HIGH_US, 70: released period for a '1' bit.
- END_LOW_US, 50: trailing low period after bit 39.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  1 = respond to start requests; sampled only in IDLE
- humidity  in  16  {integer, decimal} humidity bytes to report
- temperature  in  16  {integer, decimal} temperature bytes to report
- busy  out  1  high from the start-request accept until return to IDLE
- frame_done  out  1  one-cycle pulse when END_L completes
- debug  out  4  current state encoding
- dhtio  inout  1  single-wire bus; driven 0 when drive_low=1, else Z

Behaviour:
- Reset values: drive_low=0 (bus Z), busy=0, frame_done=0, state=IDLE, all counters 0. Reset is asynchronous, so the bus releases immediately, even mid-frame.
- Input path: `dhtio` passes through a 2-FF synchronizer (reset value 1). Edges are detected on the synchronized copy, adding 2 cycles of detection latency.
- Timing: one cycle counter, cleared on every state entry. A state lasting X_US exits when the count reaches X_US*CYC_US-1, so it lasts exactly X_US*CYC_US cycles.
- IDLE: drive_low=0. A synchronized falling edge with enable=1 goes to HOST_LOW.
- HOST_LOW: counts low cycles. The counter saturates at MIN_START_US*CYC_US and never overflows.
  - On a rising edge with count ≥ MIN_START_US*CYC_US: latch the shift register as {humidity, temperature, humidity[15:8]+humidity[7:0]+temperature[15:8]+temperature[7:0] mod 256}, set busy=1, go to WAIT_REL.
  - On a rising edge with a shorter count: go back to IDLE with no response.
- WAIT_REL (RESP_DELAY_US): drive_low=0. Bus activity is ignored.
- RESP_L (RESP_LOW_US, drive_low=1), then RESP_H (RESP_HIGH_US, drive_low=0).
- BIT_L (BIT_LOW_US, drive_low=1), then BIT_H: drive_low=0 for BIT1_HIGH_US if the current MSB is 1, else BIT0_HIGH_US. Then shift left and increment bit_cnt.
  - bit_cnt<39: go to BIT_L.
  - bit_cnt==39: go to END_L.
- END_L (END_LOW_US, drive_low=1): on exit, release the bus, pulse frame_done, clear busy, go to IDLE.
- Data order: MSB first, bit 39 to bit 0.
- Payload inputs and enable changes during a frame have no effect; the latched frame is sent.
- Host activity from WAIT_REL through END_L is ignored; bus contention is not modelled.
- A new start is only recognised from IDLE. A falling edge on the same cycle that END_L exits is missed, and the host must retry.

Optional Feature:
- Macro DHT11_RESP_CHKSUM_ERR_EN.
  - Defined: adds input `inject_err` (1 bit), sampled at latch time. If high, the checksum byte is XORed with 8'h01, giving a deliberately bad frame for checking the host's invalid-frame path.
  - Undefined: no port; the checksum is always correct.

Test Plan:
- Nominal frame: host holds low 19 ms then releases with humidity=16'h3700, temperature=16'h1A05.
  - Response low starts 30 µs (+2 sync cycles) after release; 80 µs low, 80 µs high.
  - Decoded bytes 37 00 1A 05 56; frame_done pulses once; busy=0 afterwards.
- Checksum wrap: humidity=16'hFFFF, temperature=16'hFF02 → checksum byte 8'hFF. Bit high widths are exactly 70 µs / 26 µs (7000 / 2600 cycles).
- Rejected start: host low 10 ms → dhtio never driven low by the block, busy stays 0, state back in IDLE. A subsequent 19 ms start gets a full frame.
- enable=0 during a 19 ms start → no response. Raising enable mid-frame of a later start has no effect on that frame.
- Reset during BIT_H of bit 10 → dhtio Z in the same cycle; busy=0 and debug=IDLE. The next 19 ms start yields a correct frame.
- With DHT11_RESP_CHKSUM_ERR_EN and inject_err=1 for payload 3700/1A05 → checksum byte 8'h57; the host controller reports valid=0.
